// File: rtl/tt_um_n_pwm_multi.sv
// Multi-channel PWM generator with a strobe-driven host register file.
// Duty values are double-buffered and only take effect at a period boundary.
module tt_um_n_pwm_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic                strb_meta_q, strb_sync_q, strb_prev_q;
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [CHANNELS-1:0] pol_q;
  logic [CHANNELS-1:0] chan_q;
  logic                run_q;
  logic [3:0]          pre_q;
  logic [3:0]          presc_q;
  logic [WIDTH-1:0]    cnt_q;
  logic                pulse_q;

  logic       wr;
  logic       tick;
  logic       wrap;
  logic [2:0] addr;
  logic       unused_in;

  assign addr      = ui_in[2:0];
  assign wr        = ena & strb_sync_q & ~strb_prev_q;
  // ">=" so that lowering pre below the running count ticks at once instead of wrapping
  assign tick      = run_q & (presc_q >= pre_q);
  assign wrap      = tick & (cnt_q == CntMax);
  assign unused_in = ^{ui_in[6:3], uio_in};

  // Strobe synchroniser and edge detector; frozen with the rest of the block when ena=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb_meta_q <= 1'b0;
      strb_sync_q <= 1'b0;
      strb_prev_q <= 1'b0;
    end else if (ena) begin
      strb_meta_q <= ui_in[7];
      strb_sync_q <= strb_meta_q;
      strb_prev_q <= strb_sync_q;
    end
  end

  // Host registers; with CHANNELS=7 address 6 updates both shadow_q[6] and pol_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_q <= '0;
      run_q <= 1'b0;
      pre_q <= 4'd0;
      for (int i = 0; i < CHANNELS; i++) shadow_q[i] <= '0;
    end else if (wr) begin
      if (addr == 3'd6) pol_q <= uio_in[CHANNELS-1:0];
      if (addr == 3'd7) begin
        run_q <= uio_in[0];
        pre_q <= uio_in[7:4];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (addr == 3'(i)) shadow_q[i] <= uio_in[WIDTH-1:0];
      end
    end
  end

  // Prescaler, period counter and period-start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 4'd0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else if (ena) begin
      if (!run_q) begin
        presc_q <= 4'd0;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= wrap;
        if (tick) begin
          presc_q <= 4'd0;
          cnt_q   <= cnt_q + 1'b1;
        end else begin
          presc_q <= presc_q + 4'd1;
        end
      end
    end
  end

  // Active duties reload on wrap (old shadow value wins a same-cycle write) or while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) active_q[i] <= '0;
    end else if (ena && (!run_q || wrap)) begin
      for (int i = 0; i < CHANNELS; i++) active_q[i] <= shadow_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_q <= '0;
    end else if (ena) begin
      for (int i = 0; i < CHANNELS; i++) begin
        chan_q[i] <= run_q ? ((cnt_q < active_q[i]) ^ pol_q[i]) : pol_q[i];
      end
    end
  end

  always_comb begin
    uo_out                 = 8'h00;
    uo_out[CHANNELS-1:0]   = chan_q;
    uo_out[7]              = pulse_q;
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_n_pwm_multi.sv
// Bench for tt_um_n_pwm_multi (CHANNELS=4, WIDTH=8): period/duty vector table
// plus directed sequences for buffering, enable freeze and reset.
module tb_tt_um_n_pwm_multi;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  // Per-period statistics for channel 0, updated at each period-start pulse
  int acc0      = 0;
  int len       = 0;
  int last_high0 = 0;
  int last_len  = 0;
  int npulse    = 0;

  tt_um_n_pwm_multi #(
    .CHANNELS(4),
    .WIDTH   (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc0 <= 0;
      len  <= 0;
    end else if (uo_out[7]) begin
      last_high0 <= acc0 + int'(uo_out[0]);
      last_len   <= len + 1;
      npulse     <= npulse + 1;
      acc0       <= 0;
      len        <= 0;
    end else begin
      acc0 <= acc0 + int'(uo_out[0]);
      len  <= len + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    ui_in  = {1'b1, 4'b0000, a};
    uio_in = d;
    repeat (4) @(posedge clk);
    #1;
    ui_in = 8'h00;
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_npulse(input int target, input string name);
    int guard = 0;
    while (npulse < target && guard < 3000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (npulse < target) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, pulses %0d expected %0d", name, npulse, target);
    end
  endtask

  typedef struct {
    int ch;
    int duty;
    int pol;
    int pre;
    int per;
    int high;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n0;
    int h;
    int p;
    int endp;
    int diff;
    int guard;
    logic [7:0] frozen;

    vecs[0] = '{ch: 0, duty: 64,  pol: 0, pre: 0, per: 256,  high: 64};
    vecs[1] = '{ch: 1, duty: 0,   pol: 0, pre: 0, per: 256,  high: 0};
    vecs[2] = '{ch: 2, duty: 255, pol: 0, pre: 0, per: 256,  high: 255};
    vecs[3] = '{ch: 0, duty: 64,  pol: 1, pre: 3, per: 1024, high: 768};
    vecs[4] = '{ch: 3, duty: 1,   pol: 0, pre: 1, per: 512,  high: 2};
    vecs[5] = '{ch: 3, duty: 100, pol: 8, pre: 2, per: 768,  high: 468};

    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #2 rst_n = 1'b0;
    #10;
    chk("reset_uo_out", int'(uo_out), 0);
    chk("uio_out_oe", int'({uio_out, uio_oe}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Release alone must not write or pulse
    diff = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (uo_out != 8'h00) diff++;
    end
    chk("post_reset_idle", diff, 0);

    foreach (vecs[i]) begin
      wr_reg(3'd7, 8'h00);
      wr_reg(3'(vecs[i].ch), 8'(vecs[i].duty));
      wr_reg(3'd6, 8'(vecs[i].pol));
      wr_reg(3'd7, 8'((vecs[i].pre << 4) | 1));
      wait_npulse(npulse + 1, $sformatf("v%0d_first", i));
      h = 0;
      p = 0;
      endp = 0;
      for (int k = 1; k <= vecs[i].per; k++) begin
        @(negedge clk);
        #1;
        h += int'(uo_out[vecs[i].ch]);
        if (k < vecs[i].per) p += int'(uo_out[7]);
        else endp = int'(uo_out[7]);
      end
      chk($sformatf("v%0d_high", i), h, vecs[i].high);
      chk($sformatf("v%0d_extra_pulse", i), p, 0);
      chk($sformatf("v%0d_period_end", i), endp, 1);
      chk($sformatf("v%0d_unused_bits", i), int'(uo_out[6:4]), 0);
    end

    // Stopping leaves each channel at its polarity bit
    wr_reg(3'd7, 8'h00);
    wr_reg(3'd0, 8'd64);
    wr_reg(3'd6, 8'h01);
    wr_reg(3'd7, 8'h31);
    repeat (50) @(posedge clk);
    wr_reg(3'd7, 8'h00);
    @(negedge clk);
    #1;
    chk("stopped_pol", int'(uo_out), 1);

    // Mid-period duty write applies from the next period
    wr_reg(3'd6, 8'h00);
    wr_reg(3'd7, 8'h01);
    wait_npulse(npulse + 1, "buf_start");
    n0 = npulse;
    repeat (50) @(posedge clk);
    wr_reg(3'd0, 8'd128);
    wait_npulse(n0 + 1, "buf_p1");
    chk("mid_write_cur", last_high0, 64);
    chk("mid_write_len", last_len, 256);
    wait_npulse(n0 + 2, "buf_p2");
    chk("mid_write_next", last_high0, 128);

    // Write landing on the wrap edge is delayed one more period
    n0 = npulse;
    repeat (252) @(posedge clk);
    wr_reg(3'd0, 8'd200);
    wait_npulse(n0 + 1, "wrap_p1");
    chk("wrap_write_cur", last_high0, 128);
    wait_npulse(n0 + 2, "wrap_p2");
    chk("wrap_write_delayed", last_high0, 128);
    wait_npulse(n0 + 3, "wrap_p3");
    chk("wrap_write_applied", last_high0, 200);

    // Enable freeze with a strobe pulse that must be ignored
    n0 = npulse;
    wait_npulse(n0 + 1, "ena_sync");
    repeat (50) @(posedge clk);
    #1 ena = 1'b0;
    diff = 0;
    frozen = 8'h00;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      #1;
      if (k == 1) frozen = uo_out;
      else if (uo_out != frozen) diff++;
      if (k == 10) begin
        ui_in  = 8'h80;
        uio_in = 8'd10;
      end
      if (k == 30) ui_in = 8'h00;
    end
    @(posedge clk);
    #1 ena = 1'b1;
    chk("ena_frozen", diff, 0);
    wait_npulse(n0 + 2, "ena_p2");
    chk("ena_stretched_len", last_len, 356);
    wait_npulse(n0 + 3, "ena_p3");
    chk("ena_write_ignored", last_high0, 200);
    chk("ena_len_after", last_len, 256);

    // Asynchronous reset while channel 0 is high
    guard = 0;
    while (!uo_out[0] && guard < 600) begin
      @(posedge clk);
      #3;
      guard++;
    end
    chk("reset_precond_high", int'(uo_out[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", int'(uo_out), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    diff = 0;
    repeat (300) begin
      @(negedge clk);
      #1;
      if (uo_out != 8'h00) diff++;
    end
    chk("reset_stays_idle", diff, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
